// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - registered execute-stage ALU with iterative unsigned multiply/divide
//
// Purpose: single-cycle legacy ALU operations plus WIDTH-cycle shift-add
// multiply and restoring divide, behind a start/busy/done handshake.
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   start        in   request, sampled only while busy=0
//   op[4:0]      in   operation; op[4]=0 selects legacy code op[3:0]
//   a            in   operand A (shift amount for shifts)
//   b            in   operand B
//   busy         out  multi-cycle operation in progress
//   done         out  one-cycle completion pulse
//   res          out  result low word / quotient
//   res_hi       out  product high word / remainder (0 for single-cycle ops)
//   is_zero      out  res==0, registered with res
//   div_by_zero  out  DIVU with b==0
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] res_hi,
  output logic             is_zero,
  output logic             div_by_zero
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [4:0] OP_MULU = 5'b10000;
  localparam logic [4:0] OP_DIVU = 5'b10001;

  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic             is_zero_q, is_zero_d;
  logic             dbz_q, dbz_d;

  // Iteration datapath. For multiply: acc_hi = running high word, acc_lo =
  // multiplier shifting out as product bits shift in, opnd = multiplicand.
  // For divide: acc_hi = partial remainder, acc_lo = dividend shifting out
  // as quotient bits shift in, opnd = divisor.
  logic             is_div_q, is_div_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;

  // ---------------------------------------------------------------------
  // Single-cycle legacy ALU
  // ---------------------------------------------------------------------
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] pop;
  logic [WIDTH-1:0] alu_res;

  assign sh = a[SHW-1:0];

  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + WIDTH'(b[i]);
    end
  end

  always_comb begin
    alu_res = '0;
    if (!op[4]) begin
      casez (op[3:0])
        4'b0000: alu_res = a + b;
        4'b?100: alu_res = a - b;
        4'b?001: alu_res = a & b;
        4'b?101: alu_res = a | b;
        4'b?010: alu_res = a ^ b;
        4'b1000: alu_res = pop;
        4'b?110: alu_res = b << (WIDTH / 2);
        4'b0011: alu_res = b << sh;
        4'b0111: alu_res = b >> sh;
        4'b1111: alu_res = $unsigned($signed(b) >>> sh);
        default: alu_res = '0;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // One iteration step of multiply and divide
  // ---------------------------------------------------------------------
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  always_comb begin
    mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    div_sh  = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ge  = (div_sh >= {1'b0, opnd_q});
    // Partial remainder is always below the divisor, so the difference of a
    // successful subtract fits in WIDTH bits and the dropped top bit is zero.
    div_rem = div_sh[WIDTH-1:0] - opnd_q;
    if (is_div_q) begin
      step_hi = div_ge ? div_rem : div_sh[WIDTH-1:0];
      step_lo = {acc_lo_q[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end
  end

  // ---------------------------------------------------------------------
  // Next-state and registered-output logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    res_d     = res_q;
    res_hi_d  = res_hi_q;
    is_zero_d = is_zero_q;
    dbz_d     = dbz_q;
    is_div_d  = is_div_q;
    cnt_d     = cnt_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opnd_d    = opnd_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op == OP_MULU) begin
            state_d  = S_RUN;
            busy_d   = 1'b1;
            is_div_d = 1'b0;
            cnt_d    = '0;
            acc_hi_d = '0;
            acc_lo_d = b;
            opnd_d   = a;
          end else if (op == OP_DIVU && b != '0) begin
            state_d  = S_RUN;
            busy_d   = 1'b1;
            is_div_d = 1'b1;
            cnt_d    = '0;
            acc_hi_d = '0;
            acc_lo_d = a;
            opnd_d   = b;
          end else if (op == OP_DIVU) begin
            // Divide by zero completes at once with a saturated quotient.
            done_d    = 1'b1;
            res_d     = '1;
            res_hi_d  = a;
            is_zero_d = 1'b0;
            dbz_d     = 1'b1;
          end else begin
            done_d    = 1'b1;
            res_d     = alu_res;
            res_hi_d  = '0;
            is_zero_d = (alu_res == '0);
            dbz_d     = 1'b0;
          end
        end
      end
      S_RUN: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        cnt_d    = cnt_q + SHW'(1);
        // WIDTH is a power of two, so the last step index is all ones.
        if (cnt_q == {SHW{1'b1}}) begin
          state_d   = S_IDLE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          res_d     = step_lo;
          res_hi_d  = step_hi;
          is_zero_d = (step_lo == '0);
          dbz_d     = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      res_q     <= '0;
      res_hi_q  <= '0;
      is_zero_q <= 1'b1;
      dbz_q     <= 1'b0;
      is_div_q  <= 1'b0;
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opnd_q    <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      res_q     <= res_d;
      res_hi_q  <= res_hi_d;
      is_zero_q <= is_zero_d;
      dbz_q     <= dbz_d;
      is_div_q  <= is_div_d;
      cnt_q     <= cnt_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opnd_q    <= opnd_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign res         = res_q;
  assign res_hi      = res_hi_q;
  assign is_zero     = is_zero_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - self-checking bench for seq_alu
module tb_seq_alu;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  op    = '0;
  logic [31:0] a     = '0;
  logic [31:0] b     = '0;
  logic        busy, done, is_zero, div_by_zero;
  logic [31:0] res, res_hi;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  seq_alu #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .res(res), .res_hi(res_hi),
    .is_zero(is_zero), .div_by_zero(div_by_zero)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  // Behavioural model: result of one operation from plain arithmetic.
  task automatic model_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                          output bit multi, output logic [31:0] r, output logic [31:0] h,
                          output bit dz);
    logic [63:0] p;
    multi = 1'b0; r = '0; h = '0; dz = 1'b0;
    if (o == 5'h10) begin
      multi = 1'b1;
      p = {32'b0, x} * {32'b0, y};
      r = p[31:0];
      h = p[63:32];
    end else if (o == 5'h11) begin
      if (y == 0) begin
        r = 32'hFFFF_FFFF; h = x; dz = 1'b1;
      end else begin
        multi = 1'b1; r = x / y; h = x % y;
      end
    end else if (!o[4]) begin
      case (o[3:0])
        4'd0:         r = x + y;
        4'd4, 4'd12:  r = x - y;
        4'd1, 4'd9:   r = x & y;
        4'd5, 4'd13:  r = x | y;
        4'd2, 4'd10:  r = x ^ y;
        4'd8:         r = 32'($countones(y));
        4'd6, 4'd14:  r = y * 32'h0001_0000;
        4'd3:         r = y << x[4:0];
        4'd7:         r = y >> x[4:0];
        4'd15:        r = 32'($signed(y) >>> x[4:0]);
        default:      r = '0;
      endcase
    end
  endtask

  // Cycle-level expectation: remaining iterations plus the outputs to show.
  int          rem = 0;
  logic        exp_busy = 1'b0, exp_done = 1'b0, exp_zero = 1'b1, exp_dbz = 1'b0;
  logic [31:0] exp_res = '0, exp_hi = '0, pend_res = '0, pend_hi = '0;

  always @(posedge clock) begin
    bit          m;
    logic [31:0] r, h;
    bit          dz;
    if (reset) begin
      rem = 0; exp_busy = 0; exp_done = 0; exp_res = 0; exp_hi = 0; exp_zero = 1; exp_dbz = 0;
    end else begin
      exp_done = 0;
      if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          exp_busy = 0; exp_done = 1; exp_res = pend_res; exp_hi = pend_hi;
          exp_zero = (pend_res == 0); exp_dbz = 0;
        end
      end else if (start) begin
        model_op(op, a, b, m, r, h, dz);
        if (m) begin
          rem = 32; exp_busy = 1; pend_res = r; pend_hi = h;
        end else begin
          exp_done = 1; exp_res = r; exp_hi = h; exp_zero = (r == 0); exp_dbz = dz;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("busy", 64'(busy), 64'(exp_busy));
      chk("done", 64'(done), 64'(exp_done));
      chk("res", 64'(res), 64'(exp_res));
      chk("res_hi", 64'(res_hi), 64'(exp_hi));
      chk("is_zero", 64'(is_zero), 64'(exp_zero));
      chk("div_by_zero", 64'(div_by_zero), 64'(exp_dbz));
    end
  end

  // Pulse start for one cycle; returns at the negedge after the accept edge.
  task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (!done) begin
      errors++;
      $display("FAIL wait_done timeout got=0 exp=1");
    end
  endtask

  typedef struct {
    logic [4:0]  o;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[12] = '{
    '{5'b00100, 32'd5,          32'd7,          32'hFFFF_FFFE},
    '{5'b01100, 32'd10,         32'd3,          32'd7},
    '{5'b01001, 32'hFF00_FF00,  32'h0F0F_0F0F,  32'h0F00_0F00},
    '{5'b00101, 32'hF000_0000,  32'h0000_000F,  32'hF000_000F},
    '{5'b01010, 32'hAAAA_AAAA,  32'hFFFF_0000,  32'h5555_AAAA},
    '{5'b00110, 32'd0,          32'h0000_1234,  32'h1234_0000},
    '{5'b00011, 32'h0000_0021,  32'h8000_0001,  32'h0000_0002},
    '{5'b00111, 32'd31,         32'h8000_0000,  32'h0000_0001},
    '{5'b01011, 32'd1,          32'd2,          32'h0000_0000},
    '{5'b10010, 32'd1,          32'd2,          32'h0000_0000},
    '{5'b01000, 32'd0,          32'hFFFF_FFFF,  32'h0000_0020},
    '{5'b00000, 32'd40,         32'd2,          32'h0000_002A}
  };

  initial begin
    int n;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk_en = 1'b1;
    chk("reset_res", 64'(res), 64'h0);
    chk("reset_is_zero", 64'(is_zero), 64'h1);
    chk("reset_busy", 64'(busy), 64'h0);

    // ADD wrap to zero
    issue(5'b00000, 32'hFFFF_FFFF, 32'd1);
    chk("add_done", 64'(done), 64'h1);
    chk("add_res", 64'(res), 64'h0);
    chk("add_zero", 64'(is_zero), 64'h1);

    // SRA then COUNT back-to-back
    op = 5'b01111; a = 32'h24; b = 32'h8000_0000; start = 1'b1;
    @(negedge clock);
    chk("sra_res", 64'(res), 64'hF800_0000);
    op = 5'b01000; b = 32'hF0F0_F0F0;
    @(negedge clock);
    start = 1'b0;
    chk("count_done", 64'(done), 64'h1);
    chk("count_res", 64'(res), 64'd16);

    // Table of single-cycle ops issued back-to-back
    foreach (vecs[i]) begin
      op = vecs[i].o; a = vecs[i].x; b = vecs[i].y; start = 1'b1;
      @(negedge clock);
      chk($sformatf("vec%0d_res", i), 64'(res), 64'(vecs[i].r));
    end
    start = 1'b0;
    @(negedge clock);

    // MULU full product, latency
    issue(5'b10000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(n);
    chk("mul_latency", 64'(n), 64'd32);
    chk("mul_hi", 64'(res_hi), 64'hFFFF_FFFE);
    chk("mul_lo", 64'(res), 64'h1);

    // DIVU with ignored mid-run start
    issue(5'b10001, 32'd100, 32'd7);
    repeat (5) @(negedge clock);
    op = 5'b00000; a = 32'd5; b = 32'd6; start = 1'b1;
    @(negedge clock);
    start = 1'b0; a = 32'hDEAD; b = 32'h0;
    wait_done(n);
    chk("div_q", 64'(res), 64'd14);
    chk("div_r", 64'(res_hi), 64'd2);
    @(negedge clock);
    chk("div_single_done", 64'(done), 64'h0);

    // DIVU by zero, then ADD clears the flag
    issue(5'b10001, 32'h1234, 32'h0);
    chk("dbz_done", 64'(done), 64'h1);
    chk("dbz_res", 64'(res), 64'hFFFF_FFFF);
    chk("dbz_hi", 64'(res_hi), 64'h1234);
    chk("dbz_flag", 64'(div_by_zero), 64'h1);
    issue(5'b00000, 32'd1, 32'd2);
    chk("dbz_clear", 64'(div_by_zero), 64'h0);
    chk("add3", 64'(res), 64'd3);

    // More iterative vectors, checked by the model on done
    issue(5'b10000, 32'h0001_0000, 32'h0001_0000);
    wait_done(n);
    chk("mul_2_32", 64'({res_hi, res}), 64'h1_0000_0000);
    issue(5'b10001, 32'hFFFF_FFFF, 32'd1);
    wait_done(n);
    chk("div_by_one", 64'(res), 64'hFFFF_FFFF);
    issue(5'b10001, 32'd5, 32'd9);
    wait_done(n);
    chk("div_small_zero", 64'(is_zero), 64'h1);
    chk("div_small_rem", 64'(res_hi), 64'd5);

    // Reset during RUN aborts without done
    issue(5'b10000, 32'd3, 32'd5);
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_busy", 64'(busy), 64'h0);
    chk("abort_res", 64'({res_hi, res}), 64'h0);
    chk("abort_zero", 64'(is_zero), 64'h1);
    repeat (40) @(negedge clock);
    issue(5'b10000, 32'd3, 32'd5);
    wait_done(n);
    chk("after_abort", 64'(res), 64'd15);
    repeat (3) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
